// File: rtl/sub_16bit_serial.sv
// Bit-serial 16-bit subtractor: y = a - b - b_in, computed CHUNK bits per cycle, LSB slice first.
// Three-state control (IDLE/CALC/DONE) with a one-cycle o_valid pulse; back-to-back starts from DONE.
module sub_16bit_serial #(
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        b_in,
  output logic [15:0] y,
  output logic        Bo,
  output logic        busy,
  output logic        o_valid
);

  localparam int N     = 16 / CHUNK;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int SHIFT = $clog2(CHUNK);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(CHUNK == 1 || CHUNK == 2 || CHUNK == 4 || CHUNK == 8)) begin : g_bad_chunk
    $error("sub_16bit_serial: CHUNK must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     a_q, b_q;
  logic            borrow_q;
  logic [CW-1:0]   cnt_q;

  logic            load, step, last;
  logic [3:0]      base;
  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]  diff;

  // NOTE: every sequential block uses non-blocking (<=) so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default at the top of the comb block, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One slice per CALC cycle; the extra top bit of diff is the borrow out of that slice.
  always_comb begin
    base    = 4'(cnt_q) << SHIFT;
    a_slice = a_q[base +: CHUNK];
    b_slice = b_q[base +: CHUNK];
    diff    = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow_q};
  end

  // NOTE: operand, borrow and counter registers are all reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      y        <= '0;
      Bo       <= 1'b0;
    end else if (load) begin
      a_q      <= a;
      b_q      <= b;
      borrow_q <= b_in;
      cnt_q    <= '0;
    end else if (step) begin
      y[base +: CHUNK] <= diff[CHUNK-1:0];
      borrow_q         <= diff[CHUNK];
      if (last) Bo <= diff[CHUNK];
      else      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_16bit_serial.sv
// Directed bench for sub_16bit_serial: CHUNK=4 main instance plus CHUNK=1 and CHUNK=8 instances.
// Expected values are hand-computed constants; each comparison is an immediate assertion.
module tb_sub_16bit_serial;

  logic        clk;
  logic        rst_n;
  logic        start4, start1, start8;
  logic [15:0] a, b;
  logic        b_in;

  logic [15:0] y4, y1, y8;
  logic        bo4, bo1, bo8;
  logic        busy4, busy1, busy8;
  logic        ov4, ov1, ov8;

  int checks = 0;
  int errors = 0;

  sub_16bit_serial #(.CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .b_in(b_in),
    .y(y4), .Bo(bo4), .busy(busy4), .o_valid(ov4)
  );

  sub_16bit_serial #(.CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .b_in(b_in),
    .y(y1), .Bo(bo1), .busy(busy1), .o_valid(ov1)
  );

  sub_16bit_serial #(.CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a), .b(b), .b_in(b_in),
    .y(y8), .Bo(bo8), .busy(busy8), .o_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 -> CHUNK=4, 1 -> CHUNK=1, 2 -> CHUNK=8
  task automatic sample(input int which, output logic [15:0] yy, output logic bo,
                        output logic bz, output logic ov);
    case (which)
      1:       begin yy = y1; bo = bo1; bz = busy1; ov = ov1; end
      2:       begin yy = y8; bo = bo8; bz = busy8; ov = ov8; end
      default: begin yy = y4; bo = bo4; bz = busy4; ov = ov4; end
    endcase
  endtask

  // Called at a negedge. Pulses start for one cycle, scrambles operands after capture,
  // then checks latency, busy length, result, and that o_valid is a single-cycle pulse.
  task automatic op(input string tag, input int which, input logic [15:0] aa,
                    input logic [15:0] bb, input logic bi, input int exp_edges,
                    input logic [15:0] ey, input logic ebo);
    int edges = 0;
    int busy_cnt = 0;
    logic seen = 1'b0;
    logic [15:0] yy;
    logic bo, bz, ov;
    a = aa; b = bb; b_in = bi;
    start4 = (which == 0); start1 = (which == 1); start8 = (which == 2);
    while (!seen && edges < 40) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        start4 = 1'b0; start1 = 1'b0; start8 = 1'b0;
        a = ~aa; b = ~bb; b_in = ~bi;
      end
      sample(which, yy, bo, bz, ov);
      if (bz) busy_cnt++;
      if (ov) seen = 1'b1;
    end
    check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_busy_cycles"}, busy_cnt, exp_edges - 1);
    check({tag, "_y"}, yy, ey);
    check({tag, "_bo"}, bo, ebo);
    @(negedge clk);
    sample(which, yy, bo, bz, ov);
    check({tag, "_ovalid_drop"}, ov, 1'b0);
    check({tag, "_idle_busy"}, bz, 1'b0);
    check({tag, "_y_hold"}, yy, ey);
  endtask

  initial begin
    int pulses;
    int pe[4];
    int n;
    logic [15:0] yy;
    logic bo, bz, ov;

    rst_n = 1'b1;
    start4 = 1'b0; start1 = 1'b0; start8 = 1'b0;
    a = 16'h0; b = 16'h0; b_in = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_y", y4, 16'h0000);
    check("rst_bo", bo4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_ovalid", ov4, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First start on the first rising edge after release.
    op("basic", 0, 16'h1234, 16'h0234, 1'b0, 5, 16'h1000, 1'b0);

    // Idle with start low holds the result.
    repeat (3) @(negedge clk);
    check("idle_hold_y", y4, 16'h1000);
    check("idle_hold_busy", busy4, 1'b0);

    // Full borrow ripple across all three slice widths.
    op("wrap_c4", 0, 16'h0000, 16'h0001, 1'b0, 5, 16'hFFFF, 1'b1);
    op("wrap_c1", 1, 16'h0000, 16'h0001, 1'b0, 17, 16'hFFFF, 1'b1);
    op("wrap_c8", 2, 16'h0000, 16'h0001, 1'b0, 3, 16'hFFFF, 1'b1);

    // Borrow-in boundaries.
    op("bin_zero", 0, 16'h8000, 16'h7FFF, 1'b1, 5, 16'h0000, 1'b0);
    op("bin_under", 0, 16'h0000, 16'h0000, 1'b1, 5, 16'hFFFF, 1'b1);
    op("bin_under_c1", 1, 16'h8000, 16'h7FFF, 1'b1, 17, 16'h0000, 1'b0);

    // Start while busy is ignored: exactly one pulse with the first result.
    a = 16'h00FF; b = 16'h000F; b_in = 1'b0; start4 = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start4 = 1'b0;
      if (i == 2) begin a = 16'h0001; b = 16'h0002; start4 = 1'b1; end
      if (i == 3) start4 = 1'b0;
      if (ov4) begin
        if (pulses < 4) pe[pulses] = i;
        pulses++;
        check("busy_start_y", y4, 16'h00F0);
        check("busy_start_bo", bo4, 1'b0);
      end
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_latency", pe[0], 5);

    // Start held high: back-to-back operations every N+1 cycles.
    a = 16'h0005; b = 16'h0003; b_in = 1'b0; start4 = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (ov4) begin
        if (pulses < 4) pe[pulses] = i;
        pulses++;
        check("b2b_y", y4, 16'h0002);
        check("b2b_bo", bo4, 1'b0);
      end
    end
    check("b2b_pulses", pulses, 3);
    check("b2b_first", pe[0], 5);
    check("b2b_second", pe[1], 10);
    check("b2b_third", pe[2], 15);
    start4 = 1'b0;
    n = 0;
    while ((busy4 || ov4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain_timeout", (n < 20), 1'b1);

    // Reset asserted in the second CALC cycle aborts with no o_valid.
    a = 16'hFFFF; b = 16'h0001; b_in = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    check("abort_in_calc", busy4, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_y", y4, 16'h0000);
    check("abort_bo", bo4, 1'b0);
    check("abort_busy", busy4, 1'b0);
    check("abort_ovalid", ov4, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ov4) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    rst_n = 1'b1;
    op("post_abort", 0, 16'h1234, 16'h0234, 1'b0, 5, 16'h1000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
